ex_mem_pipe: RTL
================

// Module: ex_mem_pipe
// PURPOSE
//  EX/MEM pipeline register with a 2-entry skid buffer, sitting between the EX stage and the MEM slice.
//  Carries the EX results (control M/WB, flags, ALU result/address, store data, branch target) into MEM.
//  Provides valid/ready flow control so a slow data memory can backpressure EX without losing a beat.
//  Supports branch flush. Gates MEM control bits on bubbles so DM is never read or written by an invalid slot.
// PARAMETERS
//  DW      16  datapath width: alu_res, wdata, pc_branch
//  MW       3  width of M control field: [0]=MemRead, [1]=MemWrite, [2]=Branch
//  WBW      2  width of WB control field
//  FW       3  width of flags field (zr, neg, ov)
// PORTS
//  clk          in   1    rising-edge clock
//  rst          in   1    asynchronous, active-low reset
//  in_valid     in   1    EX presents a valid instruction this cycle
//  in_ready     out  1    ex_mem_pipe can accept; EX transfers when in_valid & in_ready
//  in_m         in   MW   M control from EX
//  in_wb        in   WBW  WB control from EX
//  in_flags     in   FW   flags from ALU
//  in_alu       in   DW   ALU result (also the DM address)
//  in_wdata     in   DW   store data
//  in_pcbranch  in   DW   branch target
//  flush        in   1    kill all held and incoming instructions (taken branch)
//  out_valid    out  1    MEM-side slot is valid
//  out_ready    in   1    MEM consumes; transfer when out_valid & out_ready
//  out_m        out  MW   M control, forced 0 when !out_valid
//  out_wb       out  WBW  WB control, forced 0 when !out_valid
//  out_flags    out  FW   held flags
//  out_alu      out  DW   held ALU result / address
//  out_wdata    out  DW   held store data
//  out_pcbranch out  DW   held branch target
//  stall_cnt    out  16   only with EX_MEM_PERF_EN: saturating count of backpressure cycles
// BEHAVIOUR
//  - Storage: main slot (drives out_*) and skid slot, each payload + valid bit. All outputs come from registers.
//  - States are encoded by the {skid_v, main_v} pair:
//    - EMPTY = 00
//    - ONE   = 01
//    - TWO   = 11
//    - 10 is illegal; an assertion checks it never occurs.
//  - in_ready = !skid_v (registered, no combinational path from out_ready).
//  - Latency: a beat accepted at edge N is visible on out_* after edge N (1 cycle).
//  - EMPTY:
//    - accept -> ONE; the beat is loaded into main.
//  - ONE:
//    - accept & consume -> ONE; the new beat is loaded into main.
//    - accept & !consume -> TWO; the new beat is loaded into skid.
//    - consume only -> EMPTY.
//    - neither -> hold.
//  - TWO (in_ready=0, no accept):
//    - consume -> ONE; skid moves to main and skid_v clears.
//    - no consume -> hold.
//  - Order is strictly preserved: skid always holds the younger beat.
//  - flush:
//    - At the next edge main_v and skid_v clear (-> EMPTY).
//    - A beat accepted in the flush cycle is discarded.
//    - A consume in the flush cycle still counts as delivered to MEM.
//    - flush has priority over every other event.
//  - Payload registers are not cleared on flush or consume, only on reset. Valid bits are authoritative.
//  - Bubble gating: out_m and out_wb are 0 whenever out_valid=0, so a bubble yields no DM read/write, no branch and no writeback.
//  - Reset (rst=0, async):
//    - main_v = skid_v = 0, all payload = 0.
//    - out_valid = 0, in_ready = 1, out_* = 0, stall_cnt = 0.
//  - Reset mid-operation drops held beats immediately; no partial state survives.
// CONFIGURATION
//  - EX_MEM_PERF_EN defined:
//    - Port stall_cnt exists.
//    - Increments by 1 each cycle out_valid & !out_ready, saturating at 16'hFFFF.
//    - Cleared only by reset.
//  - EX_MEM_PERF_EN undefined: the port and counter logic are absent. All other behaviour is identical.
// STRUCTURE
//  - Shared package cpu_pkg:
//    - typedef ex_mem_t, a packed struct {m, wb, flags, alu, wdata, pcbranch}.
//    - localparams M_MEMREAD=0, M_MEMWRITE=1, M_BRANCH=2.
//  - No sub-module: two ex_mem_t registers plus valid-bit next-state logic in one module.
// TESTING
//  - Reset:
//    - rst=0 with in_valid=1 -> out_valid=0, in_ready=1, out_m=0.
//    - After rst release with stall_cnt enabled -> stall_cnt=0.
//  - Streaming:
//    - out_ready=1, 4 back-to-back beats alu=16'h0010..0013 -> out_alu shows 0010..0013 on consecutive cycles, each 1 cycle after accept.
//    - in_ready stays 1 throughout.
//  - Backpressure:
//    - out_ready=0, send A=16'hAAAA then B=16'hBBBB -> in_ready=0 after B.
//    - out_alu holds AAAA.
//    - Raise out_ready -> A then B delivered in order, then in_ready=1.
//  - Flush in TWO:
//    - Flush while holding A,B, with in_valid=1 C -> next cycle out_valid=0 and out_m=0.
//    - A, B, C never appear; in_ready=1.
//  - Bubble gating:
//    - Beat with in_m=3'b010 consumed, no new input -> out_m=3'b000 next cycle, so no DM write.
//  - Perf (EX_MEM_PERF_EN):
//    - Hold out_ready=0 for 5 cycles with out_valid=1 -> stall_cnt=5.
//    - Forcing stall_cnt to 16'hFFFF then stalling -> it stays at FFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared EX/MEM payload definitions: field widths, M-control bit positions
// and the packed beat carried from EX into MEM.
package cpu_pkg;

   localparam int EX_DW  = 16;
   localparam int EX_MW  = 3;
   localparam int EX_WBW = 2;
   localparam int EX_FW  = 3;

   localparam int M_MEMREAD  = 0;
   localparam int M_MEMWRITE = 1;
   localparam int M_BRANCH   = 2;

   typedef struct packed {
      logic [EX_MW-1:0]  m;
      logic [EX_WBW-1:0] wb;
      logic [EX_FW-1:0]  flags;
      logic [EX_DW-1:0]  alu;
      logic [EX_DW-1:0]  wdata;
      logic [EX_DW-1:0]  pcbranch;
   } ex_mem_t;

endpackage

// File: rtl/ex_mem_pipe.sv
// EX/MEM register with 2-entry skid; 1-cycle latency; in_ready = !skid_v (registered).
// Optional EX_MEM_PERF_EN adds a saturating stall_cnt of out_valid & !out_ready cycles.
module ex_mem_pipe
   import cpu_pkg::*;
#(
   parameter int DW  = EX_DW,
   parameter int MW  = EX_MW,
   parameter int WBW = EX_WBW,
   parameter int FW  = EX_FW
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [MW-1:0]  in_m,
   input  logic [WBW-1:0] in_wb,
   input  logic [FW-1:0]  in_flags,
   input  logic [DW-1:0]  in_alu,
   input  logic [DW-1:0]  in_wdata,
   input  logic [DW-1:0]  in_pcbranch,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [MW-1:0]  out_m,
   output logic [WBW-1:0] out_wb,
   output logic [FW-1:0]  out_flags,
   output logic [DW-1:0]  out_alu,
   output logic [DW-1:0]  out_wdata,
   output logic [DW-1:0]  out_pcbranch
`ifdef EX_MEM_PERF_EN
   ,
   output logic [15:0]    stall_cnt
`endif
);

   ex_mem_t main_q, skid_q, in_beat;
   logic    main_v, skid_v;
   logic    accept, consume;

   assign in_beat = '{m: in_m, wb: in_wb, flags: in_flags, alu: in_alu,
                      wdata: in_wdata, pcbranch: in_pcbranch};

   assign in_ready = !skid_v;
   assign accept   = in_valid && !skid_v;
   assign consume  = main_v && out_ready;

   // skid only ever holds the younger beat, so it refills main on consume
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
         main_q <= '0;
         skid_q <= '0;
      end else if (flush) begin
         main_v <= 1'b0;
         skid_v <= 1'b0;
      end else begin
         case ({skid_v, main_v})
            2'b00: begin
               if (accept) begin
                  main_q <= in_beat;
                  main_v <= 1'b1;
               end
            end
            2'b01: begin
               if (accept && consume) begin
                  main_q <= in_beat;
               end else if (accept) begin
                  skid_q <= in_beat;
                  skid_v <= 1'b1;
               end else if (consume) begin
                  main_v <= 1'b0;
               end
            end
            2'b11: begin
               if (consume) begin
                  main_q <= skid_q;
                  skid_v <= 1'b0;
               end
            end
            default: begin
               main_v <= 1'b0;
               skid_v <= 1'b0;
            end
         endcase
      end
   end

   a_no_skid_without_main: assert property (@(posedge clk) disable iff (!rst)
      !(skid_v && !main_v));

   // control bits are gated so a bubble can never touch DM, branch or writeback
   assign out_valid    = main_v;
   assign out_m        = main_v ? main_q.m  : '0;
   assign out_wb       = main_v ? main_q.wb : '0;
   assign out_flags    = main_q.flags;
   assign out_alu      = main_q.alu;
   assign out_wdata    = main_q.wdata;
   assign out_pcbranch = main_q.pcbranch;

`ifdef EX_MEM_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (main_v && !out_ready && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule
